// File: rtl/enc_seg_mux.sv
`default_nettype none
// ============================================================================
// Module   : enc_seg_mux
// Two-digit multiplexed seven-segment driver with sequential double-dabble
// binary-to-BCD conversion and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module enc_seg_mux #(
   parameter int VAL_W        = 5,
   parameter int REFRESH_BITS = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [VAL_W-1:0] val,
   output logic             an,
   output logic [6:0]       seg,
   output logic             busy
);

   localparam int       c_SR_W  = VAL_W + 8;
   localparam logic [2:0] c_LAST = 3'(VAL_W - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   state_t                  r_state;
   logic [VAL_W-1:0]        r_val_q;
   logic [VAL_W-1:0]        r_cur_val;
   logic [c_SR_W-1:0]       r_shift;
   logic [2:0]              r_cnt;
   logic [3:0]              r_tens;
   logic [3:0]              r_ones;
   logic                    r_busy;
   logic [REFRESH_BITS-1:0] r_refresh;
   logic                    r_an;
   logic [6:0]              r_seg;

   logic [c_SR_W-1:0]       w_adj;
   logic [c_SR_W-1:0]       w_shifted;
   logic                    w_an_next;
   logic [3:0]              w_digit;
   logic [6:0]              w_seg_next;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      case (d)
         4'd0:    f_decode = 7'h3F;
         4'd1:    f_decode = 7'h06;
         4'd2:    f_decode = 7'h5B;
         4'd3:    f_decode = 7'h4F;
         4'd4:    f_decode = 7'h66;
         4'd5:    f_decode = 7'h6D;
         4'd6:    f_decode = 7'h7D;
         4'd7:    f_decode = 7'h07;
         4'd8:    f_decode = 7'h7F;
         4'd9:    f_decode = 7'h6F;
         default: f_decode = 7'h00;
      endcase
   endfunction

   // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
   always_comb begin
      w_adj = r_shift;
      if (r_shift[c_SR_W-1 -: 4] >= 4'd5)
         w_adj[c_SR_W-1 -: 4] = r_shift[c_SR_W-1 -: 4] + 4'd3;
      if (r_shift[VAL_W+3 -: 4] >= 4'd5)
         w_adj[VAL_W+3 -: 4] = r_shift[VAL_W+3 -: 4] + 4'd3;
      w_shifted = w_adj << 1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_val_q   <= '0;
         r_cur_val <= '0;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_tens    <= '0;
         r_ones    <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_val_q <= val;
         case (r_state)
            S_IDLE: begin
               if (r_val_q != r_cur_val) begin
                  r_shift   <= {8'b0, r_val_q};
                  r_cur_val <= r_val_q;
                  r_cnt     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_CONV;
               end
            end
            S_CONV: begin
               r_shift <= w_shifted;
               r_cnt   <= r_cnt + 3'd1;
               if (r_cnt == c_LAST) begin
                  r_tens  <= w_shifted[c_SR_W-1 -: 4];
                  r_ones  <= w_shifted[VAL_W+3 -: 4];
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_an_next  = (&r_refresh) ? ~r_an : r_an;
   assign w_digit    = w_an_next ? r_tens : r_ones;
   // Tens digit of zero is blanked rather than shown as a leading "0".
   assign w_seg_next = (!en || (w_an_next && (r_tens == 4'd0))) ? 7'h00
                                                                : f_decode(w_digit);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_refresh <= '0;
         r_an      <= 1'b0;
         r_seg     <= 7'h00;
      end else begin
         r_refresh <= r_refresh + 1'b1;
         r_an      <= w_an_next;
         r_seg     <= w_seg_next;
      end
   end

   assign an   = r_an;
   assign seg  = r_seg;
   assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_enc_seg_mux.sv
`default_nettype none
// Scoreboard bench for enc_seg_mux: stimulus pushes per-edge expectations,
// a negedge monitor pops and compares them.
module tb_enc_seg_mux;

   localparam int VAL_W = 5;
   localparam int RB    = 3;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             en    = 1'b1;
   logic [VAL_W-1:0] val   = '0;
   logic             an;
   logic [6:0]       seg;
   logic             busy;

   always #5 clk = ~clk;

   enc_seg_mux #(
      .VAL_W        (VAL_W),
      .REFRESH_BITS (RB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .val   (val),
      .an    (an),
      .seg   (seg),
      .busy  (busy)
   );

   typedef struct {
      int         cyc;
      int         tag;
      logic       an;
      logic [6:0] seg;
      logic       busy;
   } exp_t;

   exp_t q[$];
   int   edges  = 0;
   int   rel    = 0;
   int   tag    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) edges <= edges + 1;

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= edges) begin
         e = q.pop_front();
         checks = checks + 1;
         if (e.cyc != edges) begin
            errors = errors + 1;
            $display("FAIL stale tag=%0d cyc=%0d now=%0d", e.tag, e.cyc, edges);
         end else if (an !== e.an || seg !== e.seg || busy !== e.busy) begin
            errors = errors + 1;
            $display("FAIL out tag=%0d cyc=%0d got an=%b seg=%h busy=%b exp an=%b seg=%h busy=%b",
                     e.tag, e.cyc, an, seg, busy, e.an, e.seg, e.busy);
         end
      end
   end

   function automatic logic exp_an(input int k);
      return k[3];
   endfunction

   task automatic step(input logic [6:0] s1, input logic [6:0] s0, input logic b);
      exp_t e;
      int   k;
      @(posedge clk); #1;
      k      = edges - rel + 1;
      e.cyc  = edges;
      e.tag  = tag;
      e.an   = exp_an(k);
      e.seg  = !en ? 7'h00 : (e.an ? s1 : s0);
      e.busy = b;
      q.push_back(e);
   endtask

   task automatic show(input int n, input logic [6:0] s1, input logic [6:0] s0,
                       input logic b);
      for (int i = 0; i < n; i++) step(s1, s0, b);
   endtask

   task automatic rst_step();
      exp_t e;
      @(posedge clk); #1;
      e.cyc  = edges;
      e.tag  = tag;
      e.an   = 1'b0;
      e.seg  = 7'h00;
      e.busy = 1'b0;
      q.push_back(e);
   endtask

   task automatic conv(input logic [VAL_W-1:0] v,
                       input logic [6:0] o1, input logic [6:0] o0,
                       input logic [6:0] n1, input logic [6:0] n0);
      val = v;
      show(1, o1, o0, 1'b0);
      show(5, o1, o0, 1'b1);
      show(1, o1, o0, 1'b0);
      show(12, n1, n0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog edges=%0d", edges);
      $fatal(1, "watchdog");
   end

   initial begin
      tag = 0;
      rst_step();
      rst_step();
      rst_n = 1'b1;
      rel   = edges + 1;

      tag = 1;
      show(20, 7'h00, 7'h3F, 1'b0);

      tag = 2;
      conv(5'd23, 7'h00, 7'h3F, 7'h5B, 7'h4F);

      tag = 3;
      conv(5'd31, 7'h5B, 7'h4F, 7'h4F, 7'h06);
      conv(5'd9,  7'h4F, 7'h06, 7'h00, 7'h6F);

      tag = 4;
      val = 5'd12;
      show(1, 7'h00, 7'h6F, 1'b0);
      show(2, 7'h00, 7'h6F, 1'b1);
      val = 5'd17;
      show(3, 7'h00, 7'h6F, 1'b1);
      show(1, 7'h00, 7'h6F, 1'b0);
      show(5, 7'h06, 7'h5B, 1'b1);
      show(1, 7'h06, 7'h5B, 1'b0);
      show(12, 7'h06, 7'h07, 1'b0);

      tag = 5;
      conv(5'd23, 7'h06, 7'h07, 7'h5B, 7'h4F);
      en = 1'b0;
      show(10, 7'h5B, 7'h4F, 1'b0);
      en = 1'b1;
      show(10, 7'h5B, 7'h4F, 1'b0);

      tag = 6;
      val = 5'd31;
      show(1, 7'h5B, 7'h4F, 1'b0);
      show(2, 7'h5B, 7'h4F, 1'b1);
      rst_n = 1'b0;
      val   = 5'd23;
      rst_step();
      rst_n = 1'b1;
      rel   = edges + 1;
      conv(5'd23, 7'h00, 7'h3F, 7'h5B, 7'h4F);

      @(negedge clk); #1;
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL leftover got=%0d exp=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/enc_seg_mux.md
# enc_seg_mux

Two-digit multiplexed seven-segment driver that consumes the 5-bit position value from the rotary-encoder stage and drives the single digit-select line plus segment bus of a two-digit display module. Converts binary to BCD with a sequential shift-add-3 (double-dabble) engine, blanks the leading zero, and time-multiplexes the two digits from a free-running refresh counter. Sits directly downstream of the encoder position counter and replaces the purely combinational display path.

## Interface
- VAL_W, 5: width of input value; legal 1..6, so the maximum value is 63 and fits in two decimal digits.
- REFRESH_BITS, 17: refresh counter width; digit select toggles every 2^REFRESH_BITS cycles.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  display enable (slide switch); 0 forces all segments off.
- val  in  VAL_W  unsigned position value from the encoder stage; asynchronous to nothing, but not assumed stable.
- an  out  1  digit select: 0 = ones digit, 1 = tens digit.
- seg  out  7  segments, active-high, seg[0]=a … seg[6]=g.
- busy  out  1  high while a BCD conversion is in progress.

## Operation
- Input capture: val_q <= val every cycle.
- Conversion FSM states: IDLE, CONV.
  - IDLE: if val_q != cur_val, load shift register {8'b0, val_q}, cur_val <= val_q, cnt <= 0, go to CONV; else stay.
  - CONV: each cycle, add 3 to any BCD nibble >= 5, then shift left 1; cnt++. On the VAL_W-th step, write the result to bcd_tens/bcd_ones and go to IDLE.
  - A val change during CONV is not aborted. On return to IDLE, val_q is compared again, so the last value always wins and intermediate values may be skipped.
- Refresh: counter of REFRESH_BITS wraps freely; on wrap, an_next = ~an, else an_next = an.
- Segment register: seg <= en ? decode(an_next ? bcd_tens : bcd_ones) : 0, with blank (0) when an_next=1 and bcd_tens==0. an <= an_next. an and seg therefore always change on the same edge.
- Decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Codes above 9 cannot occur; decode them to 0.
- an keeps toggling when en=0.

## Timing
- Reset (rst_n=0 at an edge): an=0, seg=0, busy=0, state=IDLE, refresh counter=0, val_q=0, cur_val=0, bcd=0.
- Reset asserted mid-conversion abandons the conversion; bcd returns to 0.
- First edge after reset with en=1: seg=3F (shows "0"), an=0.
- Latency: if val is captured into val_q at edge N, then:
  - CONV is entered at edge N+1;
  - bcd is written at edge N+1+VAL_W;
  - seg reflects the new digit at edge N+2+VAL_W (7 cycles for VAL_W=5), provided the matching digit is selected.
- busy=1 from edge N+1 through edge N+VAL_W inclusive (exactly VAL_W cycles).
- en change is reflected on seg on the next edge. There is no latency beyond the register.
- Digit period: an toggles every 2^REFRESH_BITS cycles (1.31 ms at 100 MHz default).

## Test plan
Bench uses REFRESH_BITS=3 and VAL_W=5.
- Reset, en=1, val=0 -> an=0 and seg=3F on the first edge after release; an toggles every 8 cycles; seg=00 while an=1 (leading blank).
- val=0->23 at capture edge N -> busy high for edges N+1..N+5; from N+7, seg=5B while an=1 and seg=4F while an=0.
- val=31 -> tens=3 (4F) and ones=1 (06). Then val=9 -> tens blanked (00) and ones=6F.
- val changes 12 -> 17 two cycles into a conversion -> the first conversion completes and shows 12. A second conversion then starts and shows 17; busy pulses twice, each pulse 5 cycles.
- en=0 while showing 23 -> seg=00 next edge, an still toggling. en=1 -> the correct digit returns next edge.
- rst_n=0 for one cycle during CONV -> seg=0, busy=0, an=0 next edge. After release with val=23 held, a fresh conversion is performed and 23 is displayed.
